fixed_requant_pipe: RTL and testbench
=====================================

Name: fixed_requant_pipe

Overview:
- Pipelined fixed-point requantiser placed directly downstream of the fixed-point activation stage.
- Re-casts each lane from the activation's (width, frac) format to a narrower output format, with round-half-up and saturation.
- Two-stage registered pipeline with full valid/ready backpressure.
- Keeps a running count of saturated lanes for calibration/debug.

Parameters:
- DATA_IN_0_PRECISION_0, 8, input total bits (signed)
- DATA_IN_0_PRECISION_1, 3, input fractional bits
- DATA_IN_0_PARALLELISM_DIM_0, 1, lanes dim 0
- DATA_IN_0_PARALLELISM_DIM_1, 1, lanes dim 1
- DATA_OUT_0_PRECISION_0, 6, output total bits (signed, ≤ input width + 8)
- DATA_OUT_0_PRECISION_1, 2, output fractional bits (may exceed input frac)
- SAT_CNT_WIDTH, 16, saturation counter width

Ports:
- clk, input, 1, clock
- rst, input, 1, reset; asynchronous, active-high
- data_in_0, input, [DATA_IN_0_PRECISION_0-1:0] x N lanes (N = DIM_0*DIM_1), input samples
- data_in_0_valid, input, 1, upstream valid
- data_in_0_ready, output, 1, this block can accept
- data_out_0, output, [DATA_OUT_0_PRECISION_0-1:0] x N lanes, requantised samples
- data_out_0_valid, output, 1, output valid
- data_out_0_ready, input, 1, downstream ready
- sat_clear, input, 1, synchronous clear of sat_count
- sat_count, output, SAT_CNT_WIDTH, saturated-lane count (sticks at all-ones)

Behaviour:
- Reset (async assert, sync release):
  - s1_valid, s2_valid, data_out_0_valid = 0
  - data_out_0 lanes = 0
  - sat_count = 0
  - data_in_0_ready = 1 after reset, since it is combinational from empty stages
- SHIFT = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1.
- Stage 1 registers the shifted value per lane at width W = DATA_IN_0_PRECISION_0 + 8 + 1, sign-extended:
  - SHIFT > 0: (x + 2^(SHIFT-1)) >>> SHIFT. Round half toward +inf; the rounding add is done at width W, so no overflow.
  - SHIFT = 0: x.
  - SHIFT < 0: x <<< (-SHIFT).
- Stage 2 registers the saturated value:
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Record a per-lane saturation flag.
- Handshake, with s2_adv = s1_valid && (!s2_valid || data_out_0_ready):
  - data_out_0_valid = s2_valid.
  - data_in_0_ready = !s1_valid || s2_adv.
  - Input accepted when data_in_0_valid && data_in_0_ready.
  - s1 loads on accept. s1_valid clears when s2_adv occurs without a new accept.
  - s2 loads on s2_adv. s2_valid clears on output handshake without s2_adv.
- Latency: 2 cycles from input accept to data_out_0_valid, with no backpressure. Throughput is 1 beat/cycle.
- Hold rule: data_out_0 and data_out_0_valid are stable while valid && !ready. There is no combinational path from data_in_0 to data_out_0.
- Backpressure: when both stages are full and data_out_0_ready = 0, data_in_0_ready = 0. This is a combinational path from data_out_0_ready to data_in_0_ready, which is accepted.
- Saturation counter:
  - On each s2_adv, sat_count += number of saturated lanes in the s1 data, computed combinationally from stage-1 values.
  - Saturates at 2^SAT_CNT_WIDTH-1 (no wrap).
  - sat_clear in the same cycle as an increment: clear wins and that increment is dropped.
- Reset mid-operation: all in-flight beats are discarded. No partial output is visible after reset.
- Static checks (initial assert): DATA_OUT_0_PRECISION_1 < DATA_OUT_0_PRECISION_0; |SHIFT| ≤ 8.

Decomposition:
- Package fixed_requant_pkg:
  - localparams/functions for SHIFT, W, OUT_MAX, OUT_MIN
  - function popcount for lane flags
- Sub-module fixed_requant_lane: purely combinational per-lane round/shift function and saturate function (two outputs: shifted value, saturated value + flag), instantiated N times.
- Top-level fixed_requant_pipe owns all registers, the handshake and the counter.

Test Plan:
- Rounding, in (8,3) → out (6,2), N=1, ready=1:
  - 0x05 → 0x03 after 2 cycles
  - 0xFB (-5) → 0x3E (-2)
  - 0xFD (-3) → 0x3F (-1)
- Saturation:
  - 0x7F → 0x1F; 0x80 → 0x20
  - sat_count = 2 after both beats
  - sat_clear together with a third saturating beat → sat_count = 0
- Backpressure: stream 0x00..0x09 at full rate while data_out_0_ready toggles 1,0,0,1 every cycle.
  - Outputs appear in order with no loss or duplication.
  - data_in_0_ready drops to 0 only when both stages are full.
  - Output is stable during stall.
- SHIFT < 0 config (out (8,5)): 0x03 → 0x0C; 0x20 → 0x7F saturated.
- Reset mid-stream: assert rst with both stages full.
  - Valid drops to 0 immediately (async) and data_out_0 = 0.
  - First beat after release appears 2 cycles after accept.
- Counter ceiling: SAT_CNT_WIDTH=2, N=2, feed three all-saturating beats → sat_count sticks at 3.

Source files
------------

// File: rtl/fixed_requant_pkg.sv
// Shared constants and helpers for the fixed-point requantiser pipeline.
package fixed_requant_pkg;

    // Extra headroom bits above the input width for the stage-1 value.
    localparam int HEADROOM = 9;

    // Largest lane count the saturation popcount can handle.
    localparam int MAX_LANES = 64;

    // Right-shift amount that moves the input binary point to the output one.
    // A negative value means the output has more fractional bits (left shift).
    function automatic int calc_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    // Width of the sign-extended stage-1 value. Large enough that neither the
    // rounding add nor a left shift of up to 8 bits can overflow.
    function automatic int calc_w(input int in_w);
        return in_w + HEADROOM;
    endfunction

    // Largest value representable in a signed out_w-bit result.
    function automatic longint out_max(input int out_w);
        return (longint'(1) << (out_w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed out_w-bit result.
    function automatic longint out_min(input int out_w);
        return -(longint'(1) << (out_w - 1));
    endfunction

    // Number of set lane flags (unused upper bits must be zero).
    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] flags);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n += int'(flags[i]);
        end
        return n;
    endfunction

endpackage : fixed_requant_pkg

// File: rtl/fixed_requant_lane.sv
// Purely combinational per-lane arithmetic: round/shift of a raw input sample
// into the wide stage-1 format, and saturation of a stage-1 value into the
// narrow output format.
module fixed_requant_lane
    import fixed_requant_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 3,
    parameter int OUT_W    = 6,
    parameter int OUT_FRAC = 2
) (
    input  logic [IN_W-1:0]                    x,
    input  logic signed [calc_w(IN_W)-1:0]     s,
    output logic signed [calc_w(IN_W)-1:0]     shifted,
    output logic [OUT_W-1:0]                   sat,
    output logic                               flag
);

    localparam int SHIFT = calc_shift(IN_FRAC, OUT_FRAC);
    localparam int W     = calc_w(IN_W);

    localparam logic signed [W-1:0] SAT_MAX = W'(out_max(OUT_W));
    localparam logic signed [W-1:0] SAT_MIN = W'(out_min(OUT_W));

    logic signed [W-1:0] x_ext;

    assign x_ext = {{(W - IN_W){x[IN_W-1]}}, x};

    if (SHIFT > 0) begin : g_round
        // Adding half an output LSB before the arithmetic shift gives
        // round-half-toward-+inf; the add cannot overflow at width W.
        localparam logic signed [W-1:0] HALF = W'(longint'(1) << (SHIFT - 1));
        logic signed [W-1:0] biased;
        assign biased  = x_ext + HALF;
        assign shifted = biased >>> SHIFT;
    end else if (SHIFT == 0) begin : g_pass
        assign shifted = x_ext;
    end else begin : g_scale_up
        assign shifted = x_ext <<< (-SHIFT);
    end

    // Clamp the stage-1 value into the output range and flag any clipping.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        sat  = OUT_W'(s);
        flag = 1'b0;
        if (s > SAT_MAX) begin
            sat  = OUT_W'(SAT_MAX);
            flag = 1'b1;
        end else if (s < SAT_MIN) begin
            sat  = OUT_W'(SAT_MIN);
            flag = 1'b1;
        end
    end

endmodule : fixed_requant_lane

// File: rtl/fixed_requant_pipe.sv
// Two-stage requantiser pipeline with valid/ready backpressure and a sticky
// saturated-lane counter. Stage 1 holds the rounded/shifted wide value,
// stage 2 holds the saturated output presented downstream.
module fixed_requant_pipe
    import fixed_requant_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 3,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int DATA_OUT_0_PRECISION_0      = 6,
    parameter int DATA_OUT_0_PRECISION_1      = 2,
    parameter int SAT_CNT_WIDTH               = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    input  logic                              sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]          sat_count
);

    localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int W     = calc_w(DATA_IN_0_PRECISION_0);
    localparam int SHIFT = calc_shift(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);
    localparam int SUM_W = SAT_CNT_WIDTH + $clog2(N + 1);

    localparam logic [SAT_CNT_WIDTH-1:0] CNT_MAX = '1;

    // Elaboration-time parameter sanity checks.
    if (DATA_OUT_0_PRECISION_1 >= DATA_OUT_0_PRECISION_0) begin : g_bad_out_frac
        $error("fixed_requant_pipe: output frac bits must be below output width");
    end
    if (SHIFT > 8 || SHIFT < -8) begin : g_bad_shift
        $error("fixed_requant_pipe: |in_frac - out_frac| must not exceed 8");
    end
    if (N > MAX_LANES) begin : g_bad_lanes
        $error("fixed_requant_pipe: lane count exceeds popcount width");
    end

    logic                              s1_valid;
    logic                              s2_valid;
    logic signed [W-1:0]               s1_data      [N];
    logic signed [W-1:0]               lane_shifted [N];
    logic [DATA_OUT_0_PRECISION_0-1:0] lane_sat     [N];
    logic [N-1:0]                      lane_flag;
    logic [MAX_LANES-1:0]              flag_vec;
    logic [SUM_W-1:0]                  sat_sum;
    logic [SAT_CNT_WIDTH-1:0]          sat_next;
    logic                              accept;
    logic                              s2_adv;

    for (genvar i = 0; i < N; i++) begin : g_lane
        fixed_requant_lane #(
            .IN_W     (DATA_IN_0_PRECISION_0),
            .IN_FRAC  (DATA_IN_0_PRECISION_1),
            .OUT_W    (DATA_OUT_0_PRECISION_0),
            .OUT_FRAC (DATA_OUT_0_PRECISION_1)
        ) u_lane (
            .x       (data_in_0[i]),
            .s       (s1_data[i]),
            .shifted (lane_shifted[i]),
            .sat     (lane_sat[i]),
            .flag    (lane_flag[i])
        );
    end

    // Handshake: stage 2 advances when it is empty or being drained; the input
    // is ready whenever stage 1 is empty or moving on this cycle.
    assign s2_adv           = s1_valid && (!s2_valid || data_out_0_ready);
    assign data_in_0_ready  = !s1_valid || s2_adv;
    assign accept           = data_in_0_valid && data_in_0_ready;
    assign data_out_0_valid = s2_valid;

    // Saturated-lane count of the beat leaving stage 1, added with headroom
    // and clamped so the counter sticks at all-ones instead of wrapping.
    always_comb begin
        flag_vec        = '0;
        flag_vec[N-1:0] = lane_flag;
        sat_sum         = SUM_W'(sat_count) + SUM_W'(popcount(flag_vec));
        sat_next        = (sat_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sat_sum[SAT_CNT_WIDTH-1:0];
    end

    // Stage-1 data capture on input accept.
    // NOTE: pure datapath registers carry no reset; their contents are only
    // observed once the matching valid bit, which is reset, says so.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                s1_data[i] <= lane_shifted[i];
            end
        end
    end

    // Stage-1 occupancy.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is always updated with non-blocking assignments.
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage-2 occupancy and output register; cleared on reset so no stale
    // beat is visible after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                data_out_0[i] <= '0;
            end
        end else if (s2_adv) begin
            s2_valid <= 1'b1;
            for (int i = 0; i < N; i++) begin
                data_out_0[i] <= lane_sat[i];
            end
        end else if (data_out_0_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Saturation counter; a clear drops any increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (s2_adv) begin
            sat_count <= sat_next;
        end
    end

endmodule : fixed_requant_pipe

// File: tb/tb_fixed_requant_pipe.sv
// Directed bench for fixed_requant_pipe: a rounding/saturation vector table
// on the default configuration plus hand-written sequences for backpressure,
// mid-stream reset, left-shift scaling and the counter ceiling.
module tb_fixed_requant_pipe;

    typedef struct {
        logic [7:0] din;
        logic [5:0] dout;
        logic       sat;
    } vec_t;

    localparam int NV = 14;

    logic clk;
    logic rst;

    // Instance A: default (8,3) -> (6,2), one lane.
    logic [7:0]  a_din  [1];
    logic [5:0]  a_dout [1];
    logic        a_valid, a_in_ready, a_out_valid, a_ready, a_clr;
    logic [15:0] a_cnt;

    // Instance B: (8,3) -> (8,5), left shift by 2.
    logic [7:0]  b_din  [1];
    logic [7:0]  b_dout [1];
    logic        b_valid, b_in_ready, b_out_valid, b_ready, b_clr;
    logic [15:0] b_cnt;

    // Instance C: two lanes, 2-bit saturation counter.
    logic [7:0]  c_din  [2];
    logic [5:0]  c_dout [2];
    logic        c_valid, c_in_ready, c_out_valid, c_ready, c_clr;
    logic [1:0]  c_cnt;

    int n_vec = 0;
    int n_bad = 0;

    vec_t tbl [NV];

    fixed_requant_pipe u_a (
        .clk(clk), .rst(rst),
        .data_in_0(a_din), .data_in_0_valid(a_valid), .data_in_0_ready(a_in_ready),
        .data_out_0(a_dout), .data_out_0_valid(a_out_valid), .data_out_0_ready(a_ready),
        .sat_clear(a_clr), .sat_count(a_cnt)
    );

    fixed_requant_pipe #(
        .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(5)
    ) u_b (
        .clk(clk), .rst(rst),
        .data_in_0(b_din), .data_in_0_valid(b_valid), .data_in_0_ready(b_in_ready),
        .data_out_0(b_dout), .data_out_0_valid(b_out_valid), .data_out_0_ready(b_ready),
        .sat_clear(b_clr), .sat_count(b_cnt)
    );

    fixed_requant_pipe #(
        .DATA_IN_0_PARALLELISM_DIM_0(2), .SAT_CNT_WIDTH(2)
    ) u_c (
        .clk(clk), .rst(rst),
        .data_in_0(c_din), .data_in_0_valid(c_valid), .data_in_0_ready(c_in_ready),
        .data_out_0(c_dout), .data_out_0_valid(c_out_valid), .data_out_0_ready(c_ready),
        .sat_clear(c_clr), .sat_count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sat;
        int sent, got, in_flight, cyc;
        logic       stalled_prev;
        logic [5:0] held;
        logic [3:0] bp_pat;

        tbl[0]  = '{8'h05, 6'h03, 1'b0};
        tbl[1]  = '{8'hFB, 6'h3E, 1'b0};
        tbl[2]  = '{8'hFD, 6'h3F, 1'b0};
        tbl[3]  = '{8'h00, 6'h00, 1'b0};
        tbl[4]  = '{8'h01, 6'h01, 1'b0};
        tbl[5]  = '{8'h03, 6'h02, 1'b0};
        tbl[6]  = '{8'h3E, 6'h1F, 1'b0};
        tbl[7]  = '{8'h3F, 6'h1F, 1'b1};
        tbl[8]  = '{8'h7F, 6'h1F, 1'b1};
        tbl[9]  = '{8'hC0, 6'h20, 1'b0};
        tbl[10] = '{8'hBF, 6'h20, 1'b0};
        tbl[11] = '{8'hBE, 6'h20, 1'b1};
        tbl[12] = '{8'h80, 6'h20, 1'b1};
        tbl[13] = '{8'hC1, 6'h21, 1'b0};

        rst = 1'b1;
        a_din[0] = '0; a_valid = 0; a_ready = 1; a_clr = 0;
        b_din[0] = '0; b_valid = 0; b_ready = 1; b_clr = 0;
        c_din[0] = '0; c_din[1] = '0; c_valid = 0; c_ready = 1; c_clr = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_dout",      a_dout[0],   6'h00);
        check("rst_cnt",       a_cnt,       16'h0);
        check("rst_in_ready",  a_in_ready,  1'b1);
        rst = 1'b0;
        tick();

        // ---- table: rounding and saturation boundaries at full rate ----
        exp_sat = 0;
        for (int i = 0; i < NV; i++) exp_sat += int'(tbl[i].sat);
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                a_valid  = 1'b1;
                a_din[0] = tbl[i].din;
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 2) begin
                check($sformatf("tbl_valid[%0d]", i - 2), a_out_valid, 1'b1);
                check($sformatf("tbl_dout[%0d]", i - 2),  a_dout[0],   tbl[i-2].dout);
            end else begin
                check($sformatf("tbl_latency[%0d]", i), a_out_valid, 1'b0);
            end
            tick();
        end
        check("tbl_sat_count", a_cnt, 64'(exp_sat));

        // ---- saturation counter and clear/increment collision ----
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        check("clr_idle", a_cnt, 16'h0);
        a_valid = 1'b1; a_din[0] = 8'h7F; tick();
        a_din[0] = 8'h80; tick();
        a_valid = 1'b0;
        check("sat_pos_dout", a_dout[0], 6'h1F);
        check("sat_cnt1",     a_cnt,     16'd1);
        tick();
        check("sat_neg_dout", a_dout[0], 6'h20);
        check("sat_cnt2",     a_cnt,     16'd2);
        a_valid = 1'b1; a_din[0] = 8'h7F; tick();
        a_valid = 1'b0; a_clr = 1'b1; tick();
        a_clr = 1'b0;
        check("clr_wins_dout",  a_dout[0], 6'h1F);
        check("clr_wins_cnt",   a_cnt,     16'd0);
        tick();
        check("clr_wins_drain", a_out_valid, 1'b0);

        // ---- backpressure: 0..9 at full rate, ready pattern 1,0,0,1 ----
        bp_pat = 4'b1001;
        sent = 0; got = 0; in_flight = 0; cyc = 0;
        stalled_prev = 1'b0; held = '0;
        while (got < 10 && cyc < 200) begin
            a_ready  = bp_pat[cyc % 4];
            a_valid  = (sent < 10);
            a_din[0] = 8'(sent);
            @(negedge clk);
            check($sformatf("bp_in_ready[%0d]", cyc), a_in_ready,
                  !(in_flight == 2 && !a_ready));
            if (stalled_prev) begin
                check($sformatf("bp_hold_valid[%0d]", cyc), a_out_valid, 1'b1);
                check($sformatf("bp_hold_data[%0d]", cyc),  a_dout[0],   held);
            end
            if (a_out_valid && a_ready) begin
                check($sformatf("bp_order[%0d]", got), a_dout[0], 6'((got + 1) >> 1));
                got++;
                in_flight--;
            end
            stalled_prev = a_out_valid && !a_ready;
            held         = a_dout[0];
            if (a_valid && a_in_ready) begin
                sent++;
                in_flight++;
            end
            tick();
            cyc++;
        end
        a_valid = 1'b0; a_ready = 1'b1;
        check("bp_all_out", 64'(got), 64'd10);
        tick(); tick();
        check("bp_no_dup", a_out_valid, 1'b0);

        // ---- reset with both stages full ----
        a_ready = 1'b0;
        a_valid = 1'b1; a_din[0] = 8'h05; tick();
        a_din[0] = 8'h7F; tick();
        a_valid = 1'b0;
        @(negedge clk);
        check("full_valid",    a_out_valid, 1'b1);
        check("full_in_ready", a_in_ready,  1'b0);
        rst = 1'b1;
        #1;
        check("arst_valid",    a_out_valid, 1'b0);
        check("arst_dout",     a_dout[0],   6'h00);
        check("arst_in_ready", a_in_ready,  1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        a_ready = 1'b1;
        a_valid = 1'b1; a_din[0] = 8'hFB;
        tick();
        a_valid = 1'b0;
        check("post_rst_lat1", a_out_valid, 1'b0);
        tick();
        check("post_rst_valid", a_out_valid, 1'b1);
        check("post_rst_dout",  a_dout[0],   6'h3E);
        check("post_rst_cnt",   a_cnt,       16'd0);
        tick();
        check("post_rst_drain", a_out_valid, 1'b0);

        // ---- left-shift configuration ----
        b_valid = 1'b1; b_din[0] = 8'h03; tick();
        b_din[0] = 8'h20; tick();
        b_valid = 1'b0;
        check("shl_dout0", b_dout[0], 8'h0C);
        check("shl_cnt0",  b_cnt,     16'd0);
        tick();
        check("shl_dout1", b_dout[0], 8'h7F);
        check("shl_cnt1",  b_cnt,     16'd1);

        // ---- counter ceiling: two lanes, 2-bit counter ----
        c_din[0] = 8'h7F; c_din[1] = 8'h80;
        c_valid = 1'b1; tick();
        tick();
        check("ceil_lane0", c_dout[0], 6'h1F);
        check("ceil_lane1", c_dout[1], 6'h20);
        check("ceil_cnt1",  c_cnt,     2'd2);
        tick();
        c_valid = 1'b0;
        check("ceil_cnt2",  c_cnt,     2'd3);
        tick();
        check("ceil_cnt3",  c_cnt,     2'd3);
        c_clr = 1'b1; tick(); c_clr = 1'b0;
        check("ceil_clr",   c_cnt,     2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fixed_requant_pipe
